// File: rtl/rv32_pkg.sv
// Shared RV32IM front-end definitions: control-flow opcodes, PC source select
// and fetch FSM states.
package rv32_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_EX,
    SEL_MRET,
    SEL_TRAP,
    SEL_HOLD
  } pc_sel_e;

  typedef enum logic {
    BOOT,
    RUN
  } fsm_e;

  // True for any opcode that can redirect the PC from EX.
  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Control-flow target computation with instruction-alignment check; shared by
// the PC generator and the EX-stage branch unit.
module pc_target_calc #(
  parameter int unsigned XLEN  = 32,
  parameter bit          C_EXT = 1'b0
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic            i_is_jalr,
  output logic [XLEN-1:0] o_target_c,
  output logic            o_misaligned_c
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;

  always_comb begin
    w_base = i_is_jalr ? i_rs1_data : i_pc;
    w_sum  = w_base + i_imm;
  end

  // JALR clears bit 0, so with 2-byte alignment it can never be misaligned.
  always_comb begin
    o_target_c = i_is_jalr ? (w_sum & ~XLEN'(1)) : w_sum;
    if (C_EXT) begin
      o_misaligned_c = o_target_c[0];
    end else begin
      o_misaligned_c = o_target_c[1];
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Registered program-counter generator for the RV32IM fetch stage with
// prioritised redirection, fetch handshake and redirect epoch tagging.
module pc_gen
  import rv32_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter bit              C_EXT        = 1'b0,
  parameter int unsigned     EPOCH_W      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [XLEN-1:0]    fetch_pc,
  output logic [EPOCH_W-1:0] fetch_epoch,
  input  logic               stall,
  input  logic               ex_valid,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [XLEN-1:0]    ex_imm,
  input  logic [XLEN-1:0]    ex_rs1_data,
  input  logic               ex_branch_taken,
  input  logic               ex_jump,
  input  logic               ex_is_jalr,
  input  logic               trap,
  input  logic [XLEN-1:0]    trap_vector,
  input  logic               mret,
  input  logic [XLEN-1:0]    mepc,
  output logic               misalign,
  output logic [XLEN-1:0]    misalign_addr
);

  localparam logic [XLEN-1:0] SEQ_STEP   = XLEN'(4);
  localparam logic [XLEN-1:0] TRAP_ALIGN = ~XLEN'(3);

  fsm_e               r_state;
  fsm_e               w_state_nxt;
  pc_sel_e            w_sel;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    w_pc_nxt;
  logic [EPOCH_W-1:0] r_epoch;
  logic [EPOCH_W-1:0] w_epoch_nxt;
  logic               r_misalign;
  logic [XLEN-1:0]    r_misalign_addr;
  logic               w_fetch_valid;
  logic               w_ex_redirect;
  logic [XLEN-1:0]    w_ex_target;
  logic               w_ex_misaligned;
  logic               w_misalign_nxt;

  pc_target_calc #(
    .XLEN  (XLEN),
    .C_EXT (C_EXT)
  ) u_target (
    .i_pc           (ex_pc),
    .i_imm          (ex_imm),
    .i_rs1_data     (ex_rs1_data),
    .i_is_jalr      (ex_jump & ex_is_jalr),
    .o_target_c     (w_ex_target),
    .o_misaligned_c (w_ex_misaligned)
  );

  assign w_ex_redirect  = ex_valid & (ex_jump | ex_branch_taken);
  assign w_misalign_nxt = w_ex_redirect & w_ex_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, fetch request and PC source in priority order.
  always_comb begin
    w_state_nxt   = r_state;
    w_fetch_valid = 1'b0;
    w_sel         = SEL_HOLD;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_fetch_valid = ~stall;
      default: w_state_nxt = BOOT;
    endcase
    if (trap) begin
      w_sel = SEL_TRAP;
    end else if (mret) begin
      w_sel = SEL_MRET;
    end else if (w_ex_redirect && !w_ex_misaligned) begin
      w_sel = SEL_EX;
    end else if (w_fetch_valid && fetch_ready) begin
      w_sel = SEL_SEQ;
    end
  end

  // Every redirect bumps the epoch; the sequential step and hold do not.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_epoch_nxt = r_epoch;
    case (w_sel)
      SEL_TRAP: begin
        w_pc_nxt    = trap_vector & TRAP_ALIGN;
        w_epoch_nxt = r_epoch + EPOCH_W'(1);
      end
      SEL_MRET: begin
        w_pc_nxt    = mepc;
        w_epoch_nxt = r_epoch + EPOCH_W'(1);
      end
      SEL_EX: begin
        w_pc_nxt    = w_ex_target;
        w_epoch_nxt = r_epoch + EPOCH_W'(1);
      end
      SEL_SEQ: w_pc_nxt = r_pc + SEQ_STEP;
      default: w_pc_nxt = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_VECTOR;
      r_epoch <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_epoch <= w_epoch_nxt;
    end
  end

  // Misaligned EX target reported for one cycle, independent of trap/mret.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_misalign <= w_misalign_nxt;
      if (w_misalign_nxt) begin
        r_misalign_addr <= w_ex_target;
      end
    end
  end

  assign fetch_valid   = w_fetch_valid;
  assign fetch_pc      = r_pc;
  assign fetch_epoch   = r_epoch;
  assign misalign      = r_misalign;
  assign misalign_addr = r_misalign_addr;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen: one instance per alignment mode,
// both driven by the same stimulus.
module tb_pc_gen;

  logic        clk;
  logic        rst_n;
  logic        fetch_ready;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1_data;
  logic        ex_branch_taken;
  logic        ex_jump;
  logic        ex_is_jalr;
  logic        trap;
  logic [31:0] trap_vector;
  logic        mret;
  logic [31:0] mepc;

  logic        a_valid, b_valid;
  logic [31:0] a_pc, b_pc;
  logic [1:0]  a_epoch, b_epoch;
  logic        a_mis, b_mis;
  logic [31:0] a_mis_addr, b_mis_addr;

  int checks;
  int failures;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b0), .EPOCH_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .fetch_valid(a_valid), .fetch_ready(fetch_ready),
    .fetch_pc(a_pc), .fetch_epoch(a_epoch), .stall(stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .ex_is_jalr(ex_is_jalr),
    .trap(trap), .trap_vector(trap_vector), .mret(mret), .mepc(mepc),
    .misalign(a_mis), .misalign_addr(a_mis_addr)
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b1), .EPOCH_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .fetch_valid(b_valid), .fetch_ready(fetch_ready),
    .fetch_pc(b_pc), .fetch_epoch(b_epoch), .stall(stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
    .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump), .ex_is_jalr(ex_is_jalr),
    .trap(trap), .trap_vector(trap_vector), .mret(mret), .mepc(mepc),
    .misalign(b_mis), .misalign_addr(b_mis_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid        = 1'b0;
    ex_jump         = 1'b0;
    ex_is_jalr      = 1'b0;
    ex_branch_taken = 1'b0;
    ex_pc           = '0;
    ex_imm          = '0;
    ex_rs1_data     = '0;
  endtask

  task automatic chk_a(input string tag, input logic [31:0] pc, input logic [1:0] ep,
                       input logic valid);
    chk({tag, "_pc"}, a_pc, pc);
    chk({tag, "_epoch"}, 32'(a_epoch), 32'(ep));
    chk({tag, "_valid"}, 32'(a_valid), 32'(valid));
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    fetch_ready = 1'b0;
    stall       = 1'b0;
    trap        = 1'b0;
    trap_vector = '0;
    mret        = 1'b0;
    mepc        = '0;
    clear_ex();

    // Reset values
    #12;
    chk_a("rst", 32'h1000, 2'd0, 1'b0);
    chk("rst_mis", 32'(a_mis), 32'd0);
    chk("rst_mis_addr", a_mis_addr, 32'h0);

    // Release away from the edge; BOOT holds fetch_valid low for one cycle
    step();
    rst_n = 1'b1;
    fetch_ready = 1'b1;
    chk("boot_valid", 32'(a_valid), 32'd0);
    step();
    chk_a("run0", 32'h1000, 2'd0, 1'b1);
    step();
    chk_a("run1", 32'h1004, 2'd0, 1'b1);
    step();
    chk_a("run2", 32'h1008, 2'd0, 1'b1);
    step();
    chk_a("run3", 32'h100C, 2'd0, 1'b1);

    // JAL to 0x2000 while imem is not ready
    fetch_ready = 1'b0;
    ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 32'h1000; ex_imm = 32'h1000;
    step();
    clear_ex();
    chk_a("jal", 32'h2000, 2'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_a("noready", 32'h2000, 2'd1, 1'b1);
    end

    // Stall suppresses the request and holds pc
    stall = 1'b1;
    fetch_ready = 1'b1;
    step();
    chk_a("stall", 32'h2000, 2'd1, 1'b0);
    stall = 1'b0;
    fetch_ready = 1'b0;

    // JALR to (0x3003+4)&~1 = 0x3006
    ex_valid = 1'b1; ex_jump = 1'b1; ex_is_jalr = 1'b1;
    ex_rs1_data = 32'h3003; ex_imm = 32'h4;
    step();
    clear_ex();
    chk_a("jalr_c0", 32'h2000, 2'd1, 1'b1);
    chk("jalr_c0_mis", 32'(a_mis), 32'd1);
    chk("jalr_c0_addr", a_mis_addr, 32'h3006);
    chk("jalr_c1_pc", b_pc, 32'h3006);
    chk("jalr_c1_epoch", 32'(b_epoch), 32'd2);
    chk("jalr_c1_mis", 32'(b_mis), 32'd0);
    step();
    chk("mis_pulse_end", 32'(a_mis), 32'd0);
    chk("mis_hold_pc", a_pc, 32'h2000);

    // Trap beats mret, taken branch and sequential step
    trap = 1'b1; trap_vector = 32'h8000_0101;
    mret = 1'b1; mepc = 32'h400;
    ex_valid = 1'b1; ex_branch_taken = 1'b1; ex_pc = 32'h100; ex_imm = 32'h8;
    fetch_ready = 1'b1;
    step();
    trap = 1'b0; mret = 1'b0; fetch_ready = 1'b0;
    clear_ex();
    chk_a("trap_prio", 32'h8000_0100, 2'd2, 1'b1);
    chk("trap_prio_mis", 32'(a_mis), 32'd0);

    // Misaligned branch (0x102) alongside trap: trap redirects, misalign still pulses
    trap = 1'b1; trap_vector = 32'h500;
    ex_valid = 1'b1; ex_branch_taken = 1'b1; ex_pc = 32'h100; ex_imm = 32'h2;
    step();
    trap = 1'b0;
    clear_ex();
    chk_a("trap_mis", 32'h500, 2'd3, 1'b1);
    chk("trap_mis_flag", 32'(a_mis), 32'd1);
    chk("trap_mis_addr", a_mis_addr, 32'h102);

    // Jump to top of address space; epoch wraps 3 -> 0, pc+4 wraps to 0
    ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 32'h0; ex_imm = 32'hFFFF_FFFC;
    step();
    clear_ex();
    chk_a("top", 32'hFFFF_FFFC, 2'd0, 1'b1);
    fetch_ready = 1'b1;
    step();
    fetch_ready = 1'b0;
    chk_a("pc_wrap", 32'h0, 2'd0, 1'b1);

    // Four taken branches: epoch 1,2,3,0
    ex_valid = 1'b1; ex_branch_taken = 1'b1; ex_pc = 32'h40; ex_imm = 32'h10;
    step();
    chk_a("br1", 32'h50, 2'd1, 1'b1);
    step();
    chk_a("br2", 32'h50, 2'd2, 1'b1);
    step();
    chk_a("br3", 32'h50, 2'd3, 1'b1);
    step();
    chk_a("br4", 32'h50, 2'd0, 1'b1);

    // ex_valid with no jump and no taken branch
    ex_branch_taken = 1'b0;
    ex_imm = 32'h200;
    step();
    clear_ex();
    chk_a("ex_nop", 32'h50, 2'd0, 1'b1);

    // mret alone
    mret = 1'b1; mepc = 32'h400;
    step();
    mret = 1'b0;
    chk_a("mret", 32'h400, 2'd1, 1'b1);

    // Asynchronous reset mid-cycle during a pending trap
    trap = 1'b1; trap_vector = 32'h700;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 32'h1000, 2'd0, 1'b0);
    chk("async_rst_mis", 32'(a_mis), 32'd0);
    step();
    trap = 1'b0;
    rst_n = 1'b1;
    chk_a("post_rst", 32'h1000, 2'd0, 1'b0);
    step();
    chk_a("post_boot", 32'h1000, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
